// File: rtl/multiport_banked_ram.sv
// NUM_PORTS-requester RAM split into 1<<TAG_W banks, each with round-robin read and write arbiters.
// Define BANKED_RAM_WR_FWD_EN to forward same-cycle write data to a read of the same address.
module multiport_banked_ram #(
  parameter int NUM_PORTS    = 2,
  parameter int TAG_W        = 2,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 13,
  parameter int LOCAL_ADDR_W = ADDR_WIDTH - TAG_W
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_PORTS-1:0]             s_read_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_read_addr,
  output logic [NUM_PORTS-1:0]             s_read_gnt,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  s_read_data,
  output logic [NUM_PORTS-1:0]             s_read_valid,
  input  logic [NUM_PORTS-1:0]             s_write_req,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  s_write_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_write_data,
  output logic [NUM_PORTS-1:0]             s_write_gnt
);

  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int DEPTH    = 1 << LOCAL_ADDR_W;
  localparam int PTR_W    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [TAG_W-1:0]        rd_bank  [NUM_PORTS];
  logic [TAG_W-1:0]        wr_bank  [NUM_PORTS];
  logic [LOCAL_ADDR_W-1:0] rd_local [NUM_PORTS];
  logic [LOCAL_ADDR_W-1:0] wr_lport [NUM_PORTS];

  logic [PTR_W-1:0]        rr_rd    [NUM_TAGS];
  logic [PTR_W-1:0]        rr_wr    [NUM_TAGS];
  logic                    rd_any   [NUM_TAGS];
  logic                    wr_any   [NUM_TAGS];
  logic [PTR_W-1:0]        rd_win   [NUM_TAGS];
  logic [PTR_W-1:0]        wr_win   [NUM_TAGS];
  logic [LOCAL_ADDR_W-1:0] wr_local [NUM_TAGS];
  logic [DATA_WIDTH-1:0]   wr_data  [NUM_TAGS];

  logic [DATA_WIDTH-1:0]   mem      [NUM_TAGS][DEPTH];
  logic [DATA_WIDTH-1:0]   rd_word  [NUM_PORTS];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] w);
    if (w == PTR_W'(NUM_PORTS - 1)) return '0;
    return w + 1'b1;
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_bank[p]  = s_read_addr[p*ADDR_WIDTH + ADDR_WIDTH - 1 -: TAG_W];
      wr_bank[p]  = s_write_addr[p*ADDR_WIDTH + ADDR_WIDTH - 1 -: TAG_W];
      rd_local[p] = s_read_addr[p*ADDR_WIDTH +: LOCAL_ADDR_W];
      wr_lport[p] = s_write_addr[p*ADDR_WIDTH +: LOCAL_ADDR_W];
    end
  end

  // Per bank: scan ports starting at the pointer, first requester targeting this bank wins.
  always_comb begin
    logic found_r;
    logic found_w;
    int   ri;
    int   wi;
    s_read_gnt  = '0;
    s_write_gnt = '0;
    ri = 0;
    wi = 0;
    for (int b = 0; b < NUM_TAGS; b++) begin
      found_r     = 1'b0;
      found_w     = 1'b0;
      rd_win[b]   = '0;
      wr_win[b]   = '0;
      wr_local[b] = '0;
      wr_data[b]  = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
        ri = (int'(rr_rd[b]) + k) % NUM_PORTS;
        wi = (int'(rr_wr[b]) + k) % NUM_PORTS;
        if (!reset && !found_r && s_read_req[ri] && rd_bank[ri] == TAG_W'(b)) begin
          found_r        = 1'b1;
          rd_win[b]      = PTR_W'(ri);
          s_read_gnt[ri] = 1'b1;
        end
        if (!reset && !found_w && s_write_req[wi] && wr_bank[wi] == TAG_W'(b)) begin
          found_w         = 1'b1;
          wr_win[b]       = PTR_W'(wi);
          wr_local[b]     = wr_lport[wi];
          wr_data[b]      = s_write_data[wi*DATA_WIDTH +: DATA_WIDTH];
          s_write_gnt[wi] = 1'b1;
        end
      end
      rd_any[b] = found_r;
      wr_any[b] = found_w;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_TAGS; b++) begin
        rr_rd[b] <= '0;
        rr_wr[b] <= '0;
      end
    end else begin
      for (int b = 0; b < NUM_TAGS; b++) begin
        if (rd_any[b]) rr_rd[b] <= next_ptr(rd_win[b]);
        if (wr_any[b]) rr_wr[b] <= next_ptr(wr_win[b]);
      end
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_TAGS; b++) begin
      if (wr_any[b]) mem[b][wr_local[b]] <= wr_data[b];
    end
  end

  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      rd_word[p] = mem[rd_bank[p]][rd_local[p]];
`ifdef BANKED_RAM_WR_FWD_EN
      if (wr_any[rd_bank[p]] && wr_local[rd_bank[p]] == rd_local[p])
        rd_word[p] = wr_data[rd_bank[p]];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_read_valid <= '0;
      s_read_data  <= '0;
    end else begin
      s_read_valid <= s_read_gnt;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (s_read_gnt[p]) s_read_data[p*DATA_WIDTH +: DATA_WIDTH] <= rd_word[p];
      end
    end
  end

endmodule

// File: tb/tb_multiport_banked_ram.sv
// Scoreboard bench for multiport_banked_ram with four ports; read responses are checked by a monitor.
module tb_multiport_banked_ram;
  localparam int NP = 4;
  localparam int AW = 13;
  localparam int DW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     rreq, wreq, rgnt, wgnt, rvalid;
  logic [NP*AW-1:0]  raddr_v, waddr_v;
  logic [NP*DW-1:0]  wdata_v, rdata_v;

  multiport_banked_ram #(.NUM_PORTS(NP), .TAG_W(2), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .s_read_req(rreq), .s_read_addr(raddr_v), .s_read_gnt(rgnt),
    .s_read_data(rdata_v), .s_read_valid(rvalid),
    .s_write_req(wreq), .s_write_addr(waddr_v), .s_write_data(wdata_v),
    .s_write_gnt(wgnt)
  );

  always #5 clk = ~clk;

  typedef struct {int cyc; logic [15:0] data; bit known;} exp_t;

  exp_t        rq [NP][$];
  logic [15:0] mdl_mem   [8192];
  bit          mdl_known [8192];
  int          ptr_rd[4], ptr_wr[4];
  logic [15:0] last_exp[NP];
  bit          last_known[NP];
  bit          r_req[NP], w_req[NP], mg_r[NP], mg_w[NP];
  int          r_addr[NP], w_addr[NP], w_data[NP];
  logic [NP-1:0] act_rg, act_wg;
  int          cyc = 0;
  int          checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int bank_of(input int a);
    return (a >> 11) & 3;
  endfunction

  // Winner = requester on this bank at the smallest circular distance from the pointer.
  function automatic int winner(input int b, input int ptr, input bit wr);
    int best = -1;
    int bestd = NP;
    for (int p = 0; p < NP; p++) begin
      bit rqst = wr ? w_req[p] : r_req[p];
      int a = wr ? w_addr[p] : r_addr[p];
      if (rqst && bank_of(a) == b && ((p - ptr + NP) % NP) < bestd) begin
        bestd = (p - ptr + NP) % NP;
        best = p;
      end
    end
    return best;
  endfunction

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      rreq[p] = r_req[p];
      wreq[p] = w_req[p];
      raddr_v[p*AW +: AW] = AW'(r_addr[p]);
      waddr_v[p*AW +: AW] = AW'(w_addr[p]);
      wdata_v[p*DW +: DW] = DW'(w_data[p]);
    end
  endtask

  task automatic step();
    logic [NP-1:0] er, ew;
    int rw, ww;
    exp_t e;
    @(negedge clk);
    drive();
    #1;
    er = '0; ew = '0;
    for (int p = 0; p < NP; p++) begin mg_r[p] = 0; mg_w[p] = 0; end
    for (int b = 0; b < 4; b++) begin
      rw = winner(b, ptr_rd[b], 1'b0);
      ww = winner(b, ptr_wr[b], 1'b1);
      if (rw >= 0) begin mg_r[rw] = 1; er[rw] = 1'b1; ptr_rd[b] = (rw + 1) % NP; end
      if (ww >= 0) begin mg_w[ww] = 1; ew[ww] = 1'b1; ptr_wr[b] = (ww + 1) % NP; end
    end
    act_rg = rgnt;
    act_wg = wgnt;
    check("read_gnt", 64'(rgnt), 64'(er));
    check("write_gnt", 64'(wgnt), 64'(ew));
    for (int p = 0; p < NP; p++) begin
      if (mg_r[p]) begin
        e.cyc = cyc + 1;
        e.data = mdl_mem[r_addr[p]];
        e.known = mdl_known[r_addr[p]];
`ifdef BANKED_RAM_WR_FWD_EN
        for (int q = 0; q < NP; q++)
          if (mg_w[q] && w_addr[q] == r_addr[p]) begin e.data = 16'(w_data[q]); e.known = 1; end
`endif
        rq[p].push_back(e);
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (mg_w[p]) begin mdl_mem[w_addr[p]] = 16'(w_data[p]); mdl_known[w_addr[p]] = 1; end
    end
  endtask

  task automatic clear_granted();
    for (int p = 0; p < NP; p++) begin
      if (mg_r[p]) r_req[p] = 0;
      if (mg_w[p]) w_req[p] = 0;
    end
  endtask

  task automatic clear_all();
    for (int p = 0; p < NP; p++) begin r_req[p] = 0; w_req[p] = 0; end
  endtask

  function automatic bit any_pending();
    for (int p = 0; p < NP; p++) if (r_req[p] || w_req[p]) return 1;
    return 0;
  endfunction

  task automatic run_until_granted(input int n);
    for (int i = 0; i < n && any_pending(); i++) begin
      step();
      clear_granted();
    end
    check("grant_timeout", 64'(any_pending()), 64'd0);
    clear_all();
  endtask

  // Reset is raised between clock edges so the asynchronous clear is observable.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check("rst_valid", 64'(rvalid), 64'd0);
    check("rst_data", 64'(rdata_v), 64'd0);
    check("rst_rgnt", 64'(rgnt), 64'd0);
    check("rst_wgnt", 64'(wgnt), 64'd0);
    for (int p = 0; p < NP; p++) begin
      rq[p].delete();
      last_exp[p] = '0;
      last_known[p] = 1;
    end
    for (int b = 0; b < 4; b++) begin ptr_rd[b] = 0; ptr_wr[b] = 0; end
    clear_all();
    drive();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    for (int p = 0; p < NP; p++) begin
      if (rvalid[p]) begin
        if (rq[p].size() == 0) begin
          check("unexpected_valid", 64'(rvalid[p]), 64'd0);
        end else begin
          e = rq[p].pop_front();
          check("read_latency", 64'(cyc), 64'(e.cyc));
          if (e.known) check("read_data", 64'(rdata_v[p*DW +: DW]), 64'(e.data));
          last_exp[p] = e.data;
          last_known[p] = e.known;
        end
      end else begin
        if (rq[p].size() != 0 && rq[p][0].cyc <= cyc) begin
          e = rq[p].pop_front();
          check("missing_valid", 64'(rvalid[p]), 64'd1);
        end
        if (last_known[p]) check("data_hold", 64'(rdata_v[p*DW +: DW]), 64'(last_exp[p]));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seq;
    int got;
    for (int p = 0; p < NP; p++) begin
      last_exp[p] = '0; last_known[p] = 1;
      r_req[p] = 1; w_req[p] = 1; r_addr[p] = p; w_addr[p] = p + 16; w_data[p] = 0;
    end
    for (int b = 0; b < 4; b++) begin ptr_rd[b] = 0; ptr_wr[b] = 0; end
    reset = 1'b1;
    drive();
    #3;
    check("init_valid", 64'(rvalid), 64'd0);
    check("init_data", 64'(rdata_v), 64'd0);
    check("init_rgnt", 64'(rgnt), 64'd0);
    check("init_wgnt", 64'(wgnt), 64'd0);
    clear_all();
    drive();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Two ports writing different banks
    for (int i = 0; i < 10; i++) begin
      w_req[0] = 1; w_addr[0] = i;          w_data[0] = i;
      w_req[1] = 1; w_addr[1] = 'h800 + i;  w_data[1] = i * 'h11;
      step();
      check("diff_bank_wgnt", 64'(act_wg[1:0]), 64'd3);
    end
    clear_all();
    r_req[0] = 1; r_addr[0] = 'h005;
    r_req[1] = 1; r_addr[1] = 'h805;
    step();
    check("readback_rgnt", 64'(act_rg[1:0]), 64'd3);
    clear_all();
    @(posedge clk); #2;
    check("readback_valid", 64'(rvalid[1:0]), 64'd3);
    check("readback_p0", 64'(rdata_v[15:0]), 64'h0005);
    check("readback_p1", 64'(rdata_v[31:16]), 64'h0055);
    step();
    apply_reset();

    // Two ports contending for bank 0 writes
    w_req[0] = 1; w_addr[0] = 'h10; w_data[0] = 'hA000;
    w_req[1] = 1; w_addr[1] = 'h20; w_data[1] = 'hB000;
    for (int i = 0; i < 4; i++) begin
      step();
      seq = act_wg[0] ? 0 : (act_wg[1] ? 1 : -1);
      check("wr_rr_seq", 64'(seq), 64'(i % 2));
      for (int p = 0; p < 2; p++) if (mg_w[p]) w_data[p] = w_data[p] + 1;
    end
    clear_all();
    r_req[0] = 1; r_addr[0] = 'h10;
    r_req[1] = 1; r_addr[1] = 'h20;
    run_until_granted(4);

    // Same-cycle read and write to one address
    w_req[0] = 1; w_addr[0] = 'h100; w_data[0] = 'hABCD;
    run_until_granted(4);
    w_req[0] = 1; w_addr[0] = 'h100; w_data[0] = 'h1234;
    r_req[1] = 1; r_addr[1] = 'h100;
    step();
    clear_all();
    @(posedge clk); #2;
`ifdef BANKED_RAM_WR_FWD_EN
    check("rw_collision", 64'(rdata_v[31:16]), 64'h1234);
`else
    check("rw_collision", 64'(rdata_v[31:16]), 64'hABCD);
`endif
    r_req[1] = 1; r_addr[1] = 'h100;
    step();
    clear_all();
    @(posedge clk); #2;
    check("rw_after", 64'(rdata_v[31:16]), 64'h1234);
    step();
    apply_reset();

    // Four ports reading bank 1 every cycle
    for (int p = 0; p < NP; p++) begin r_req[p] = 1; r_addr[p] = 'h800 + p; end
    for (int i = 0; i < 8; i++) begin
      step();
      seq = -1;
      for (int p = NP - 1; p >= 0; p--) if (act_rg[p]) seq = p;
      check("rd_rr_seq", 64'(seq), 64'(i % 4));
      check("rd_onehot", 64'($countones(act_rg)), 64'd1);
    end
    clear_all();

    // Reset in the middle of read traffic
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) begin
        r_req[p] = 1;
        r_addr[p] = ($urandom_range(0, 3) << 11) | $urandom_range(0, 9);
      end
      step();
    end
    apply_reset();
    for (int p = 0; p < NP; p++) begin r_req[p] = 1; r_addr[p] = 'h805; end
    step();
    check("post_rst_first", 64'(act_rg), 64'd1);
    clear_granted();
    @(posedge clk); #2;
    check("post_rst_data", 64'(rdata_v[15:0]), 64'h0055);
    run_until_granted(8);

    // Held bank-2 read must not starve behind back-to-back reads
    w_req[2] = 1; w_addr[2] = 'h1003; w_data[2] = 'h7777;
    run_until_granted(4);
    r_req[1] = 1; r_addr[1] = 'h1003;
    got = -1;
    for (int i = 0; i < 3 && got < 0; i++) begin
      r_req[0] = 1; r_addr[0] = 'h1000 + i;
      step();
      if (act_rg[1]) got = i;
      clear_granted();
    end
    check("no_starve", 64'(got >= 0 && got <= 1), 64'd1);
    clear_all();

    // Randomized traffic holding ungranted requests stable
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (!r_req[p] && $urandom_range(0, 1) == 1) begin
          r_req[p] = 1;
          r_addr[p] = ($urandom_range(0, 3) << 11) | $urandom_range(0, 7);
        end
        if (!w_req[p] && $urandom_range(0, 2) == 0) begin
          w_req[p] = 1;
          w_addr[p] = ($urandom_range(0, 3) << 11) | $urandom_range(0, 7);
          w_data[p] = $urandom_range(0, 65535);
        end
      end
      step();
      clear_granted();
    end
    run_until_granted(16);
    step();
    step();
    @(posedge clk); #2;
    begin
      int left = 0;
      for (int p = 0; p < NP; p++) left += rq[p].size();
      check("queues_empty", 64'(left), 64'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
